// File: rtl/multi_sig_filt_if.sv
// -----------------------------------------------------------------------------
// multi_sig_filt_if
// Bundles the sensor inputs, the shared stability threshold and all per-channel
// filter results of multi_sig_filt.
//   master : drives sig_in / stbl_thresh, observes filter results
//   slave  : the filter itself
// Signals:
//   sig_in      [NUM_CH]        raw asynchronous pad inputs
//   stbl_thresh [CNT_W]         stability cycles required, shared by all channels
//   filt        [NUM_CH]        filtered level
//   filt_rise   [NUM_CH]        one-cycle pulse on filtered 0->1
//   filt_fall   [NUM_CH]        one-cycle pulse on filtered 1->0
//   raw_rise    [NUM_CH]        one-cycle synchronised (unfiltered) rising edge
//   period      [NUM_CH*PER_W]  last rise-to-rise period, channel i at [i*PER_W +: PER_W]
//   period_vld  [NUM_CH]        period holds a valid, unsaturated measurement
//   stall       [NUM_CH]        period counter saturated
// -----------------------------------------------------------------------------
interface multi_sig_filt_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PER_W  = 20
);
    logic [NUM_CH-1:0]       sig_in;
    logic [CNT_W-1:0]        stbl_thresh;
    logic [NUM_CH-1:0]       filt;
    logic [NUM_CH-1:0]       filt_rise;
    logic [NUM_CH-1:0]       filt_fall;
    logic [NUM_CH-1:0]       raw_rise;
    logic [NUM_CH*PER_W-1:0] period;
    logic [NUM_CH-1:0]       period_vld;
    logic [NUM_CH-1:0]       stall;

    modport master (
        output sig_in, stbl_thresh,
        input  filt, filt_rise, filt_fall, raw_rise, period, period_vld, stall
    );

    modport slave (
        input  sig_in, stbl_thresh,
        output filt, filt_rise, filt_fall, raw_rise, period, period_vld, stall
    );
endinterface

// File: rtl/multi_sig_filt.sv
// -----------------------------------------------------------------------------
// multi_sig_filt
// Debounce / glitch filter for NUM_CH independent asynchronous sensor inputs.
// Per channel: SYNC_STAGES-deep synchroniser, run-time programmable stability
// filter, filtered rise/fall pulses, unfiltered rise pulse, and rise-to-rise
// period measurement with stall detection.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset; clears every register
//   bus  : multi_sig_filt_if.slave (inputs, threshold and all results)
// -----------------------------------------------------------------------------
module multi_sig_filt #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int PER_W       = 20
) (
    input  logic            clk,
    input  logic            rst,
    multi_sig_filt_if.slave bus
);
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    // sync_q[0] is the first synchroniser stage, sync_q[SYNC_STAGES-1] the last
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0]                  dly_q, dly_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]                  filt_q, filt_d;
    logic [NUM_CH-1:0]                  rise_q, rise_d;
    logic [NUM_CH-1:0]                  fall_q, fall_d;
    logic [NUM_CH-1:0][PER_W-1:0]       pcnt_q, pcnt_d;
    logic [NUM_CH-1:0][PER_W-1:0]       period_q, period_d;
    logic [NUM_CH-1:0]                  vld_q, vld_d;
    logic [NUM_CH-1:0]                  first_q, first_d;

    logic [NUM_CH-1:0]                  s_w;
    logic [NUM_CH-1:0]                  changed_w;
    logic [NUM_CH-1:0]                  stall_w;

    assign s_w       = sync_q[SYNC_STAGES-1];
    assign changed_w = s_w ^ dly_q;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
        dly_d    = s_w;
        cnt_d    = cnt_q;
        filt_d   = filt_q;
        rise_d   = '0;
        fall_d   = '0;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        vld_d    = vld_q;
        first_d  = first_q;

        for (int i = 0; i < NUM_CH; i++) begin
            // Counter saturates at the threshold; a threshold raised later
            // simply lets it resume counting.
            if (changed_w[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < bus.stbl_thresh) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            // >= so a lowered threshold releases an already-stable input at once
            if (cnt_q[i] >= bus.stbl_thresh) begin
                filt_d[i] = dly_q[i];
            end

            rise_d[i] = filt_d[i] & ~filt_q[i];
            fall_d[i] = ~filt_d[i] & filt_q[i];

            if (rise_d[i]) begin
                // +1 accounts for the edge itself so P-cycle spacing reads P
                period_d[i] = (pcnt_q[i] == PER_MAX) ? PER_MAX : pcnt_q[i] + 1'b1;
                vld_d[i]    = first_q[i] & (pcnt_q[i] != PER_MAX);
                first_d[i]  = 1'b1;
                pcnt_d[i]   = '0;
            end else begin
                pcnt_d[i] = (pcnt_q[i] == PER_MAX) ? PER_MAX : pcnt_q[i] + 1'b1;
                if (pcnt_d[i] == PER_MAX) begin
                    vld_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        stall_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            stall_w[i] = (pcnt_q[i] == PER_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            dly_q    <= '0;
            cnt_q    <= '0;
            filt_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            pcnt_q   <= '0;
            period_q <= '0;
            vld_q    <= '0;
            first_q  <= '0;
        end else begin
            sync_q   <= sync_d;
            dly_q    <= dly_d;
            cnt_q    <= cnt_d;
            filt_q   <= filt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            first_q  <= first_d;
        end
    end

    assign bus.filt       = filt_q;
    assign bus.filt_rise  = rise_q;
    assign bus.filt_fall  = fall_q;
    assign bus.raw_rise   = s_w & ~dly_q;
    assign bus.period     = period_q;
    assign bus.period_vld = vld_q;
    assign bus.stall      = stall_w;

endmodule
